// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper and its environment.
// master: start/abort/expected/out_sample out, status in; slave: the sweeper.
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic       out_sample;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       done;
  logic [7:0] tt_word;
  logic       mismatch;

  modport master (
    output start, abort, expected, out_sample,
    input  in1, in2, in3, busy, done, tt_word, mismatch
  );

  modport slave (
    input  start, abort, expected, out_sample,
    output in1, in2, in3, busy, done, tt_word, mismatch
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives 000..111 onto a 3-input gate, samples its output, builds tt_word.
// Ports: clk, reset_n (async low), bus (slave). Golden compare: TT_COMPARE_EN.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  truth_table_sweeper_if.slave bus
);

  if (SETTLE_CYCLES < 1 || (2**CNT_W) < SETTLE_CYCLES) begin : g_bad
    $error("truth_table_sweeper: bad SETTLE_CYCLES/CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tt_q, tt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept, kill, finish;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    kill    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          accept  = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          tt_d    = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          kill = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        // Row 000 lands in the MSB: 7-idx == ~idx for 3 bits.
        tt_d[~idx_q] = bus.out_sample;
        if (bus.abort) begin
          kill = 1'b1;
        end else if (idx_q == 3'd7) begin
          finish  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      busy_d  = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  assign bus.in1     = idx_q[2];
  assign bus.in2     = idx_q[1];
  assign bus.in3     = idx_q[0];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.tt_word = tt_q;

`ifdef TT_COMPARE_EN
  logic [7:0] exp_q, exp_d;
  logic       mis_q, mis_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q <= '0;
      mis_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      mis_q <= mis_d;
    end
  end

  // Compare against tt_d so the bit captured in the last SAMPLE counts,
  // making mismatch valid in the same cycle as done.
  always_comb begin
    exp_d = exp_q;
    mis_d = mis_q;
    if (accept) begin
      exp_d = bus.expected;
      mis_d = 1'b0;
    end else if (kill) begin
      mis_d = 1'b0;
    end else if (finish) begin
      mis_d = (tt_d != exp_q);
    end
  end

  assign bus.mismatch = mis_q;
`else
  logic unused_cmp;
  assign unused_cmp   = ^{bus.expected, accept, finish};
  assign bus.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a NOR(in2,in3) gate model.
// Two instances: default settle time and SETTLE_CYCLES=1.
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if a ();
  truth_table_sweeper_if b ();

  assign a.out_sample = ~(a.in2 | a.in3);
  assign b.out_sample = ~(b.in2 | b.in3);

  truth_table_sweeper dut_a (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (a.slave)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .CNT_W(8)) dut_b (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (b.slave)
  );

  localparam logic EXP_MIS = `ifdef TT_COMPARE_EN 1'b1 `else 1'b0 `endif;

  int         done_at, n_done, n_busy, in_bad;
  logic [7:0] tt_done;
  logic       mis_done;
  logic       busy_after;
  logic [2:0] in_after;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts a start, then runs ncyc cycles on instance a, recording results.
  // Cycle 1 is the first cycle after the accepting edge.
  task automatic sweep(input logic [7:0] exp_w, input int pulse_at,
                       input int abort_at, input int ncyc);
    int ei;
    a.expected = exp_w;
    a.start    = 1'b1;
    tick();
    a.start  = 1'b0;
    done_at  = 0;
    n_done   = 0;
    n_busy   = 0;
    in_bad   = 0;
    tt_done  = 8'hxx;
    mis_done = 1'bx;
    for (int c = 1; c <= ncyc; c++) begin
      if (abort_at != 0 && c > abort_at) ei = 0;
      else if (c <= 40) ei = (c - 1) / 5;
      else if (c == 41) ei = 7;
      else ei = 0;
      if ({a.in1, a.in2, a.in3} !== 3'(ei)) in_bad++;
      if (a.busy === 1'b1) n_busy++;
      if (a.done === 1'b1) begin
        n_done++;
        if (done_at == 0) begin
          done_at  = c;
          tt_done  = a.tt_word;
          mis_done = a.mismatch;
        end
      end
      if (c == abort_at + 1) begin
        busy_after = a.busy;
        in_after   = {a.in1, a.in2, a.in3};
      end
      a.start = (c == pulse_at);
      a.abort = (c == abort_at);
      tick();
    end
    a.start = 1'b0;
    a.abort = 1'b0;
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    a.start    = 1'b0;
    a.abort    = 1'b0;
    a.expected = 8'h00;
    b.start    = 1'b0;
    b.abort    = 1'b0;
    b.expected = 8'h88;
    #12;
    chk("rst_in", 32'({a.in1, a.in2, a.in3}), 32'd0);
    chk("rst_busy", 32'(a.busy), 32'd0);
    chk("rst_done", 32'(a.done), 32'd0);
    chk("rst_tt", 32'(a.tt_word), 32'h00);
    chk("rst_mis", 32'(a.mismatch), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // 1/3: NOR(in2,in3) gives 0x88; inputs step every 5 cycles.
    sweep(8'h88, 0, 0, 45);
    chk("t1_done_at", 32'(done_at), 32'd41);
    chk("t1_n_done", 32'(n_done), 32'd1);
    chk("t1_busy_cycles", 32'(n_busy), 32'd41);
    chk("t1_tt", 32'(tt_done), 32'h88);
    chk("t1_mis", 32'(mis_done), 32'd0);
    chk("t3_inputs_bad", 32'(in_bad), 32'd0);
    chk("t1_tt_hold", 32'(a.tt_word), 32'h88);

    // 2: wrong golden word.
    sweep(8'h80, 0, 0, 45);
    chk("t2_done_at", 32'(done_at), 32'd41);
    chk("t2_mis_at_done", 32'(mis_done), 32'(EXP_MIS));
    chk("t2_mis_hold", 32'(a.mismatch), 32'(EXP_MIS));

    // 4: start pulse mid-sweep is ignored.
    sweep(8'h88, 10, 0, 45);
    chk("t4_done_at", 32'(done_at), 32'd41);
    chk("t4_n_done", 32'(n_done), 32'd1);
    chk("t4_mis", 32'(mis_done), 32'd0);

    // 5: abort at cycle 12 (idx=2), after rows 000 (1) and 001 (0).
    sweep(8'h80, 0, 12, 45);
    chk("t5_n_done", 32'(n_done), 32'd0);
    chk("t5_busy_after", 32'(busy_after), 32'd0);
    chk("t5_in_after", 32'(in_after), 32'd0);
    chk("t5_busy_cycles", 32'(n_busy), 32'd12);
    chk("t5_inputs_bad", 32'(in_bad), 32'd0);
    chk("t5_tt", 32'(a.tt_word), 32'h80);
    chk("t5_mis", 32'(a.mismatch), 32'd0);

    // start together with abort in IDLE is not a start.
    a.start = 1'b1;
    a.abort = 1'b1;
    tick();
    a.start = 1'b0;
    a.abort = 1'b0;
    chk("idle_abort_busy", 32'(a.busy), 32'd0);
    tick();
    chk("idle_abort_busy2", 32'(a.busy), 32'd0);

    // 6: async reset in cycle 20 of a sweep.
    a.expected = 8'h88;
    a.start    = 1'b1;
    tick();
    a.start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    chk("t6_busy_pre", 32'(a.busy), 32'd1);
    chk("t6_tt_pre", 32'(a.tt_word), 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_in", 32'({a.in1, a.in2, a.in3}), 32'd0);
    chk("t6_busy", 32'(a.busy), 32'd0);
    chk("t6_done", 32'(a.done), 32'd0);
    chk("t6_tt", 32'(a.tt_word), 32'h00);
    chk("t6_mis", 32'(a.mismatch), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_busy_post", 32'(a.busy), 32'd0);

    // 6b: SETTLE_CYCLES=1 instance, done in cycle 8*2+1.
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    n = 0;
    for (int c = 1; c <= 25; c++) begin
      if (b.done === 1'b1 && n == 0) begin
        n = c;
        chk("t6b_tt", 32'(b.tt_word), 32'h88);
        chk("t6b_mis", 32'(b.mismatch), 32'd0);
      end
      tick();
    end
    chk("t6b_done_at", 32'(n), 32'd17);
    chk("t6b_busy_end", 32'(b.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
